serial_word_tx: RTL and testbench



---
 rtl/serial_word_tx.sv | 159 +++++++++++++++
 tb/tb_serial_word_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_tx.sv
// Parallel-to-serial framer: FIFO-buffered words sent as start '1', DATA_W bits MSB-first, GAP_CYCLES '0's.
// Optional key-lock obfuscation of data bits enabled by defining CUTE_LOCK_EN.
module serial_word_tx #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_CYCLES = 2
`ifdef CUTE_LOCK_EN
   ,
   parameter logic [2:0] KEY_0 = 3'd2,
   parameter logic [2:0] KEY_1 = 3'd3,
   parameter logic [2:0] KEY_2 = 3'd4,
   parameter logic [2:0] KEY_3 = 3'd5
`endif
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx_out,
   output logic              busy,
   output logic [7:0]        frame_cnt
`ifdef CUTE_LOCK_EN
   ,
   input  logic [2:0]        keyinput
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int GW = $clog2(GAP_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, GAP} state_t;

   state_t            state, state_nx;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count;
   logic              push, pop, not_empty;
   logic [DATA_W-1:0] shift, shift_nx;
   logic [BW-1:0]     bit_cnt, bit_cnt_nx;
   logic [GW-1:0]     gap_cnt, gap_cnt_nx;
   logic              tx_nx, frame_inc, data_inv;

   // Flags come only from the registered occupancy, never from in_valid.
   assign not_empty = (count != '0);
   assign in_ready  = (count != (AW+1)'(FIFO_DEPTH));
   assign push      = in_valid & in_ready;
   assign busy      = (state != IDLE) | not_empty;

`ifdef CUTE_LOCK_EN
   logic [1:0] lock_q;
   logic [2:0] key_exp;

   always_comb begin
      key_exp = KEY_0;
      case (lock_q)
         2'd0: key_exp = KEY_0;
         2'd1: key_exp = KEY_1;
         2'd2: key_exp = KEY_2;
         2'd3: key_exp = KEY_3;
         default: key_exp = KEY_0;
      endcase
   end

   assign data_inv = (keyinput != key_exp);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) lock_q <= 2'd0;
      else          lock_q <= lock_q + 2'd1;
   end
`else
   assign data_inv = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // gap_cnt is loaded with GAP_CYCLES so that the closing edge (frame done,
   // optional back-to-back start) lands after the last idle '0' cycle.
   always_comb begin
      state_nx   = state;
      shift_nx   = shift;
      bit_cnt_nx = bit_cnt;
      gap_cnt_nx = gap_cnt;
      tx_nx      = 1'b0;
      pop        = 1'b0;
      frame_inc  = 1'b0;
      case (state)
         IDLE: begin
            if (not_empty) begin
               pop        = 1'b1;
               shift_nx   = mem[rd_ptr];
               tx_nx      = 1'b1;
               bit_cnt_nx = BW'(DATA_W - 1);
               state_nx   = DATA;
            end
         end
         DATA: begin
            tx_nx = shift[bit_cnt] ^ data_inv;
            if (bit_cnt == '0) begin
               gap_cnt_nx = GW'(GAP_CYCLES);
               state_nx   = GAP;
            end else begin
               bit_cnt_nx = bit_cnt - 1'b1;
            end
         end
         GAP: begin
            if (gap_cnt != '0) begin
               gap_cnt_nx = gap_cnt - 1'b1;
            end else begin
               frame_inc = 1'b1;
               if (not_empty) begin
                  pop        = 1'b1;
                  shift_nx   = mem[rd_ptr];
                  tx_nx      = 1'b1;
                  bit_cnt_nx = BW'(DATA_W - 1);
                  state_nx   = DATA;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         shift     <= '0;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         tx_out    <= 1'b0;
         frame_cnt <= 8'd0;
      end else begin
         state   <= state_nx;
         shift   <= shift_nx;
         bit_cnt <= bit_cnt_nx;
         gap_cnt <= gap_cnt_nx;
         tx_out  <= tx_nx;
         if (frame_inc) frame_cnt <= frame_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: framing, back-to-back, backpressure, reset, wrap, optional key lock.
module tb_serial_word_tx;

   logic       clock;
   logic       reset_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       tx_out;
   logic       busy;
   logic [7:0] frame_cnt;

   int errors = 0;
   int checks = 0;
   logic [7:0] words [256];

`ifdef CUTE_LOCK_EN
   logic [2:0] keyinput;
   logic [1:0] lk;
   bit         key_fixed;
   logic [2:0] keys [4];

   initial begin
      keys[0] = 3'd2; keys[1] = 3'd3; keys[2] = 3'd4; keys[3] = 3'd5;
      key_fixed = 1'b0;
   end

   // Independent edge counter since reset release, for driving the key in lockstep.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) lk <= 2'd0;
      else          lk <= lk + 2'd1;
   end

   always_comb keyinput = key_fixed ? 3'd0 : keys[lk];
`endif

   serial_word_tx dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .tx_out    (tx_out),
      .busy      (busy),
      .frame_cnt (frame_cnt)
`ifdef CUTE_LOCK_EN
      ,
      .keyinput  (keyinput)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      in_data  = 8'h00;
      reset_n  = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   // Expected line value p cycles after the first start bit, frames of 11 cycles.
   function automatic logic exp_bit(input int p, input bit inv);
      int f, o;
      f = p / 11;
      o = p % 11;
      if (o == 0) return 1'b1;
      if (o <= 8) return words[f][8-o] ^ inv;
      return 1'b0;
   endfunction

   // Streams words[0..n-1] with in_valid held while words remain; checks every line cycle.
   task automatic run_stream(input int n, input string tag, input bit inv, input bit chk_stall);
      int   wi;
      bit   acc;
      logic ebit;
      wi       = 0;
      in_valid = 1'b1;
      in_data  = words[0];
      for (int c = 0; c < n*11 + 2; c++) begin
         acc = in_valid && in_ready;
         @(negedge clock);
         if (acc) wi++;
         in_valid = (wi < n);
         in_data  = (wi < n) ? words[wi] : 8'h96;
         if (c == 0 || c - 1 >= n*11) ebit = 1'b0;
         else                         ebit = exp_bit(c - 1, inv);
         chk({tag, "_tx"}, tx_out, ebit);
         if (chk_stall && c >= 4 && c <= 11) chk({tag, "_ready_low"}, in_ready, 1'b0);
      end
      chk({tag, "_accepted"}, wi, n);
      chk({tag, "_frame_cnt"}, frame_cnt, n % 256);
      chk({tag, "_busy_end"}, busy, 1'b0);
   endtask

   initial begin
      logic [10:0] a5_vec;
      bit          saw_one;
      a5_vec = 11'b11010010100;
      reset_n  = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      @(negedge clock);

      // Reset state
      reset_n = 1'b0;
      #1;
      chk("rst_tx", tx_out, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", in_ready, 1'b1);
      chk("rst_frame_cnt", frame_cnt, 8'd0);
      @(negedge clock);
      reset_n = 1'b1;

      // Single A5 frame against a hand-written waveform
      in_valid = 1'b1;
      in_data  = 8'hA5;
      @(negedge clock);
      in_valid = 1'b0;
      in_data  = 8'h00;
      chk("a5_pre_tx", tx_out, 1'b0);
      chk("a5_busy", busy, 1'b1);
      for (int i = 0; i < 11; i++) begin
         @(negedge clock);
         chk("a5_tx", tx_out, a5_vec[10-i]);
      end
      chk("a5_cnt_before", frame_cnt, 8'd0);
      @(negedge clock);
      chk("a5_tx_idle", tx_out, 1'b0);
      chk("a5_frame_cnt", frame_cnt, 8'd1);
      chk("a5_busy_end", busy, 1'b0);

      // Four back-to-back frames
      do_reset();
      words[0] = 8'h01; words[1] = 8'hFF; words[2] = 8'h80; words[3] = 8'h3C;
      run_stream(4, "b2b", 1'b0, 1'b0);

      // Backpressure: six words, FIFO fills and in_ready stays low until a pop
      do_reset();
      words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
      words[3] = 8'h44; words[4] = 8'h55; words[5] = 8'h66;
      run_stream(6, "stall", 1'b0, 1'b1);

      // Reset mid-DATA of C3 with two words queued
      do_reset();
      in_valid = 1'b1;
      in_data  = 8'hC3;
      @(negedge clock);
      in_data = 8'hD1;
      @(negedge clock);
      in_data = 8'hE2;
      @(negedge clock);
      in_valid = 1'b0;
      in_data  = 8'h00;
      @(negedge clock);
      chk("mid_tx_bit6", tx_out, 1'b1);
      chk("mid_busy", busy, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_tx", tx_out, 1'b0);
      chk("mid_rst_ready", in_ready, 1'b1);
      chk("mid_rst_busy", busy, 1'b0);
      @(negedge clock);
      reset_n = 1'b1;
      saw_one = 1'b0;
      repeat (30) begin
         @(negedge clock);
         if (tx_out !== 1'b0) saw_one = 1'b1;
      end
      chk("mid_no_frames", saw_one, 1'b0);
      chk("mid_frame_cnt", frame_cnt, 8'd0);
      chk("mid_busy_end", busy, 1'b0);

      // 256 zero frames wrap frame_cnt back to 0
      do_reset();
      for (int i = 0; i < 256; i++) words[i] = 8'h00;
      run_stream(256, "wrap", 1'b0, 1'b0);

`ifdef CUTE_LOCK_EN
      // Correct key sequence: plain A5 waveform
      do_reset();
      key_fixed = 1'b0;
      words[0] = 8'hA5;
      run_stream(1, "lock_ok", 1'b0, 1'b0);
      // Wrong key throughout: data bits inverted, start and gap untouched
      do_reset();
      key_fixed = 1'b1;
      run_stream(1, "lock_bad", 1'b1, 1'b0);
      key_fixed = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
